// File: rtl/fb_render_ctrl.sv
// fb_render_ctrl: clear / draw / wait-for-swap sequencer driving the framebuffer write port.
module fb_render_ctrl #(
  parameter int ADDR_WIDTH = 17,
  parameter int H_RES = 320,
  parameter int V_RES = 240
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vsync,
  input  logic                  frame_start,
  input  logic [7:0]            clear_color,
  input  logic                  px_valid,
  output logic                  px_ready,
  input  logic [8:0]            px_x,
  input  logic [7:0]            px_y,
  input  logic [7:0]            px_color,
  input  logic                  raster_done,
  output logic                  fb_wea,
  output logic [ADDR_WIDTH-1:0] fb_addra,
  output logic [7:0]            fb_dina,
  output logic                  busy,
  output logic                  frame_swapped,
  output logic [7:0]            overrun_cnt
);
  localparam int NUM_PIXELS = H_RES * V_RES;
  typedef enum logic [1:0] {IDLE, CLEAR, DRAW, WAIT_SWAP} state_t;
  state_t state;
  logic prev_vsync, vs_fall, in_range;
  logic [7:0] color;
  logic [ADDR_WIDTH-1:0] cnt, px_addr;
  assign vs_fall  = prev_vsync & ~vsync;
  assign px_ready = state == DRAW;
  assign busy     = state != IDLE;
  assign in_range = int'(px_x) < H_RES && int'(px_y) < V_RES;
  // y*320 as two shifts, matching the framebuffer's linear layout
  assign px_addr  = (ADDR_WIDTH'(px_y) << 8) + (ADDR_WIDTH'(px_y) << 6) + ADDR_WIDTH'(px_x);
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      prev_vsync    <= 1'b0;
      color         <= '0;
      cnt           <= '0;
      fb_wea        <= 1'b0;
      fb_addra      <= '0;
      fb_dina       <= '0;
      frame_swapped <= 1'b0;
      overrun_cnt   <= '0;
    end else begin
      prev_vsync    <= vsync;
      fb_wea        <= 1'b0;
      frame_swapped <= 1'b0;
      if (vs_fall && (state == CLEAR || state == DRAW) && overrun_cnt != 8'hFF)
        overrun_cnt <= overrun_cnt + 8'd1;
      case (state)
        IDLE: if (frame_start) begin
          state <= CLEAR;
          color <= clear_color;
          cnt   <= '0;
        end
        CLEAR: begin
          fb_wea   <= 1'b1;
          fb_addra <= cnt;
          fb_dina  <= color;
          cnt      <= cnt + 1'b1;
          if (cnt == ADDR_WIDTH'(NUM_PIXELS - 1)) state <= DRAW;
        end
        DRAW: begin
          if (px_valid && in_range) begin
            fb_wea   <= 1'b1;
            fb_addra <= px_addr;
            fb_dina  <= px_color;
          end
          if (raster_done) state <= WAIT_SWAP;
        end
        WAIT_SWAP: if (vs_fall) begin
          state         <= IDLE;
          frame_swapped <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fb_render_ctrl.sv
// tb_fb_render_ctrl: directed scenarios for the framebuffer render controller.
module tb_fb_render_ctrl;
  logic clk = 0, rst = 1, vsync = 1, frame_start = 0, px_valid = 0, raster_done = 0;
  logic [7:0] clear_color = 0, px_y = 0, px_color = 0;
  logic [8:0] px_x = 0;
  logic px_ready, fb_wea, busy, frame_swapped;
  logic [16:0] fb_addra;
  logic [7:0] fb_dina, overrun_cnt;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  fb_render_ctrl dut (
    .clk(clk), .rst(rst), .vsync(vsync), .frame_start(frame_start), .clear_color(clear_color),
    .px_valid(px_valid), .px_ready(px_ready), .px_x(px_x), .px_y(px_y), .px_color(px_color),
    .raster_done(raster_done), .fb_wea(fb_wea), .fb_addra(fb_addra), .fb_dina(fb_dina),
    .busy(busy), .frame_swapped(frame_swapped), .overrun_cnt(overrun_cnt)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1;
    tick();
    tick();
    tests++; if ({fb_wea, busy, px_ready, frame_swapped} !== 4'b0) begin fails++; $display("FAIL reset_flags: got %b want 0000", {fb_wea, busy, px_ready, frame_swapped}); end
    tests++; if (fb_addra !== 17'd0 || fb_dina !== 8'd0) begin fails++; $display("FAIL reset_bus: got addr %0d data %0h want 0 0", fb_addra, fb_dina); end
    tests++; if (overrun_cnt !== 8'd0) begin fails++; $display("FAIL reset_overrun: got %0d want 0", overrun_cnt); end
    rst = 0;
    tick();
    vsync = 0;
    tick();
    tick();
    vsync = 1;
    tests++; if (overrun_cnt !== 8'd0 || busy !== 1'b0) begin fails++; $display("FAIL idle_vsync: got overrun %0d busy %b want 0 0", overrun_cnt, busy); end
    tick();
  endtask
  task automatic test_reset_mid_clear();
    bit found = 0;
    frame_start = 1;
    clear_color = 8'hA5;
    tick();
    frame_start = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      if (fb_wea && fb_addra == 17'd1000) found = 1;
      else tick();
    end
    tests++; if (!found) begin fails++; $display("FAIL mid_clear_reach: got addr %0d want 1000", fb_addra); end
    rst = 1;
    tick();
    tests++; if (fb_wea !== 1'b0) begin fails++; $display("FAIL mid_reset_wea: got %b want 0", fb_wea); end
    tests++; if ({busy, px_ready, frame_swapped} !== 3'b0 || fb_addra !== 17'd0 || fb_dina !== 8'd0) begin fails++; $display("FAIL mid_reset_outs: got busy %b rdy %b sw %b addr %0d data %0h want all 0", busy, px_ready, frame_swapped, fb_addra, fb_dina); end
    rst = 0;
    tick();
    tick();
  endtask
  task automatic test_clear();
    int bad = 0, first_bad = -1;
    frame_start = 1;
    clear_color = 8'h1C;
    tick();
    frame_start = 0;
    tests++; if (fb_wea !== 1'b0 || busy !== 1'b1 || px_ready !== 1'b0) begin fails++; $display("FAIL clear_t1: got wea %b busy %b rdy %b want 0 1 0", fb_wea, busy, px_ready); end
    for (int i = 0; i < 76800; i++) begin
      if (i == 100) vsync = 0;
      if (i == 200) vsync = 1;
      raster_done = (i == 300);
      frame_start = (i == 400);
      if (i == 400) clear_color = 8'h55;
      tick();
      if (fb_wea !== 1'b1 || fb_addra !== 17'(i) || fb_dina !== 8'h1C || px_ready !== (i == 76799)) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
    end
    raster_done = 0;
    frame_start = 0;
    tests++; if (bad != 0) begin fails++; $display("FAIL clear_writes: got %0d bad cycles (first at %0d) want 0", bad, first_bad); end
    tests++; if (overrun_cnt !== 8'd1) begin fails++; $display("FAIL clear_overrun: got %0d want 1", overrun_cnt); end
    tick();
    tests++; if (fb_wea !== 1'b0 || px_ready !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL draw_entry: got wea %b rdy %b busy %b want 0 1 1", fb_wea, px_ready, busy); end
  endtask
  task automatic test_draw();
    logic [8:0] xs [5] = '{9'd0, 9'd319, 9'd5, 9'd320, 9'd0};
    logic [7:0] ys [5] = '{8'd0, 8'd239, 8'd2, 8'd0, 8'd240};
    logic [7:0] cs [5] = '{8'hFF, 8'h03, 8'h40, 8'h11, 8'h22};
    logic [16:0] as [5] = '{17'd0, 17'd76799, 17'd645, 17'd0, 17'd0};
    px_valid = 1;
    for (int i = 0; i < 5; i++) begin
      px_x = xs[i];
      px_y = ys[i];
      px_color = cs[i];
      tick();
      if (i < 3) begin
        tests++; if (fb_wea !== 1'b1 || fb_addra !== as[i] || fb_dina !== cs[i]) begin fails++; $display("FAIL draw_px%0d: got wea %b addr %0d data %0h want 1 %0d %0h", i, fb_wea, fb_addra, fb_dina, as[i], cs[i]); end
      end else begin
        tests++; if (fb_wea !== 1'b0 || px_ready !== 1'b1) begin fails++; $display("FAIL draw_oob%0d: got wea %b rdy %b want 0 1", i, fb_wea, px_ready); end
      end
    end
    px_valid = 0;
    frame_start = 1;
    clear_color = 8'h99;
    tick();
    frame_start = 0;
    tick();
    tests++; if (fb_wea !== 1'b0 || px_ready !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL draw_ignore_start: got wea %b rdy %b busy %b want 0 1 1", fb_wea, px_ready, busy); end
    vsync = 0;
    tick();
    vsync = 1;
    tick();
    tests++; if (overrun_cnt !== 8'd2 || px_ready !== 1'b1) begin fails++; $display("FAIL draw_overrun: got %0d rdy %b want 2 1", overrun_cnt, px_ready); end
  endtask
  task automatic test_saturate();
    for (int i = 0; i < 300; i++) begin
      vsync = 0;
      tick();
      vsync = 1;
      tick();
    end
    tests++; if (overrun_cnt !== 8'd255 || px_ready !== 1'b1) begin fails++; $display("FAIL overrun_sat: got %0d rdy %b want 255 1", overrun_cnt, px_ready); end
  endtask
  task automatic test_done_with_pixel();
    int wr = 0;
    px_valid = 1;
    px_x = 9'd1;
    px_y = 8'd1;
    px_color = 8'h77;
    raster_done = 1;
    tick();
    raster_done = 0;
    px_x = 9'd0;
    px_y = 8'd0;
    tests++; if (fb_wea !== 1'b1 || fb_addra !== 17'd321 || fb_dina !== 8'h77) begin fails++; $display("FAIL done_px: got wea %b addr %0d data %0h want 1 321 77", fb_wea, fb_addra, fb_dina); end
    tests++; if (px_ready !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL wait_state: got rdy %b busy %b want 0 1", px_ready, busy); end
    for (int i = 0; i < 3; i++) begin
      tick();
      wr += int'(fb_wea) + int'(px_ready);
    end
    px_valid = 0;
    tests++; if (wr != 0) begin fails++; $display("FAIL wait_writes: got %0d want 0", wr); end
    vsync = 0;
    tests++; if (frame_swapped !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL swap_early: got sw %b busy %b want 0 1", frame_swapped, busy); end
    tick();
    tests++; if (frame_swapped !== 1'b1 || busy !== 1'b0 || fb_wea !== 1'b0) begin fails++; $display("FAIL swap_pulse: got sw %b busy %b wea %b want 1 0 0", frame_swapped, busy, fb_wea); end
    tick();
    vsync = 1;
    tests++; if (frame_swapped !== 1'b0 || overrun_cnt !== 8'd255) begin fails++; $display("FAIL swap_end: got sw %b overrun %0d want 0 255", frame_swapped, overrun_cnt); end
  endtask
  task automatic test_reset_clears_overrun();
    rst = 1;
    tick();
    rst = 0;
    tests++; if (overrun_cnt !== 8'd0) begin fails++; $display("FAIL overrun_rst: got %0d want 0", overrun_cnt); end
  endtask
  initial begin
    test_reset();
    test_reset_mid_clear();
    test_clear();
    test_draw();
    test_saturate();
    test_done_with_pixel();
    test_reset_clears_overrun();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
